// File: rtl/dsp_stream_fifo.sv
// ---------------------------------------------------------------------------
// dsp_stream_fifo
//
// Purpose:
//   Elastic first-word-fall-through buffer for the read side of the DSP
//   datapath's registered operand/result streams. A producer pushes SIZE-bit
//   words with a valid/ready handshake. A consumer pops the head word with its
//   own valid/ready handshake and can apply backpressure.
//
// Parameters:
//   SIZE   data word width in bits (default 18)
//   DEPTH  number of storage entries, power of two, 2..256 (default 4)
//
// Ports:
//   clk        rising-edge clock
//   RST        asynchronous active-low reset
//   flush      synchronous clear of contents, priority over push and pop
//   in_data    write data, sampled only on a push edge
//   in_valid   producer has a word
//   in_ready   FIFO can accept (push = in_valid && in_ready)
//   out_data   head word, registered
//   out_valid  head word present (pop = out_valid && out_ready)
//   out_ready  consumer takes the head word
//   level      current occupancy, 0..DEPTH
//   stall_cnt  (only with DSP_FIFO_STALL_CNT_EN) saturating count of cycles
//              with in_valid=1 && in_ready=0
//
// Optional feature macro: DSP_FIFO_STALL_CNT_EN
// ---------------------------------------------------------------------------
module dsp_stream_fifo #(
  parameter int SIZE  = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     flush,
  input  logic [SIZE-1:0]          in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SIZE-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
`ifdef DSP_FIFO_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LEVEL  = LW'(1);
  localparam logic [LW-1:0] ZERO_LEVEL = '0;

  logic [SIZE-1:0] mem [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic [SIZE-1:0] head_q;
  logic            out_valid_q;

  logic [PW-1:0]   wr_ptr_next;
  logic [PW-1:0]   rd_ptr_next;
  logic [PW-1:0]   rd_ptr_inc;
  logic [LW-1:0]   level_next;
  logic [SIZE-1:0] head_next;

  logic            push;
  logic            pop;

  // in_ready depends only on registered occupancy (and reset), so there is
  // never a combinational path from out_ready back to in_ready.
  assign in_ready  = RST && (level_q != FULL_LEVEL);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid_q && out_ready;

  assign out_data  = head_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;

  // Next-state computation. The head word is kept in its own register so that
  // it reads 0 after reset and keeps the last popped value when empty, even
  // though the storage array itself is never reset. The new head after an
  // edge is either the entry following the read pointer or, when the FIFO is
  // about to be (or stay) single-entry from a push, the word being pushed.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    level_next  = level_q;
    head_next   = head_q;
    rd_ptr_inc  = rd_ptr + PW'(1);

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = ZERO_LEVEL;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_inc;
      end

      unique case ({push, pop})
        2'b10: begin
          level_next = level_q + ONE_LEVEL;
          if (level_q == ZERO_LEVEL) begin
            head_next = in_data;
          end
        end
        2'b01: begin
          level_next = level_q - ONE_LEVEL;
          if (level_q != ONE_LEVEL) begin
            head_next = mem[rd_ptr_inc];
          end
        end
        2'b11: begin
          if (level_q == ONE_LEVEL) begin
            head_next = in_data;
          end else begin
            head_next = mem[rd_ptr_inc];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control state register: pointers, occupancy, head word and its valid.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= ZERO_LEVEL;
      head_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      level_q     <= level_next;
      head_q      <= head_next;
      out_valid_q <= (level_next != ZERO_LEVEL);
    end
  end

  // Storage array has no reset; its contents are only meaningful between the
  // read and write pointers, which the reset and flush paths clear.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifdef DSP_FIFO_STALL_CNT_EN
  // Saturating count of producer stall cycles; flush clears it as well.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_dsp_stream_fifo
//
// Directed testbench for dsp_stream_fifo (SIZE=18, DEPTH=4). Inputs change
// 1 time unit after each rising edge and outputs are checked at that point.
// ---------------------------------------------------------------------------
module tb_dsp_stream_fifo;

  logic        clk;
  logic        RST;
  logic        flush;
  logic [17:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
`ifdef DSP_FIFO_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total;
  int bad;

  dsp_stream_fifo #(
    .SIZE (18),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level)
`ifdef DSP_FIFO_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive all handshake inputs at once.
  task automatic applyStimulus(input logic v, input logic [17:0] d,
                               input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset held with a word offered: nothing may be accepted.
    RST = 1'b0;
    applyStimulus(1'b1, 18'h155, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_level",     32'(level),     32'd0);

    applyStimulus(1'b0, 18'h0, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rel_level",    32'(level),    32'd0);
    tick();
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

    // Fill to full with out_ready low.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 18'(i), 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("fill_level_%0d", i), 32'(level), 32'(i));
      checkOutput($sformatf("fill_head_%0d", i), 32'(out_data), 32'd1);
      checkOutput($sformatf("fill_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);

    // A fifth word is offered for 5 cycles while full: must not be stored.
    applyStimulus(1'b1, 18'h3FFFF, 1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("full_hold_level", 32'(level),    32'd4);
    checkOutput("full_hold_head",  32'(out_data), 32'd1);
`ifdef DSP_FIFO_STALL_CNT_EN
    checkOutput("stall_cnt_5", 32'(stall_cnt), 32'd5);
`endif

    // Drain in order.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 18'h3FFFF, 1'b1, 1'b0);
      checkOutput($sformatf("drain_data_%0d", k), 32'(out_data), 32'(k));
      tick();
      checkOutput($sformatf("drain_level_%0d", k), 32'(level), 32'(4 - k));
      if (k == 1) begin
        checkOutput("drain_in_ready_back", 32'(in_ready), 32'd1);
      end
    end
    checkOutput("empty_out_valid", 32'(out_valid), 32'd0);
    checkOutput("empty_hold_data", 32'(out_data),  32'd4);

    // Two words in, then push+pop at level 2.
    applyStimulus(1'b1, 18'h10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 18'h11, 1'b0, 1'b0);
    tick();
    checkOutput("sim_pre_level", 32'(level), 32'd2);
    applyStimulus(1'b1, 18'h2AAAA, 1'b1, 1'b0);
    checkOutput("sim_pop_oldest", 32'(out_data), 32'h10);
    tick();
    checkOutput("sim_level", 32'(level),    32'd2);
    checkOutput("sim_head",  32'(out_data), 32'h11);

    // Eight cycles of continuous push+pop across the pointer wrap.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 18'(32'h100 + i), 1'b1, 1'b0);
      if (i == 0) begin
        checkOutput("stream_out_0", 32'(out_data), 32'h11);
      end else if (i == 1) begin
        checkOutput("stream_out_1", 32'(out_data), 32'h2AAAA);
      end else begin
        checkOutput($sformatf("stream_out_%0d", i), 32'(out_data),
                    32'h100 + 32'(i - 2));
      end
      tick();
      checkOutput($sformatf("stream_level_%0d", i), 32'(level), 32'd2);
    end
    checkOutput("stream_tail_head", 32'(out_data), 32'h106);

    // Bring level to 3, then flush with a push and pop also requested.
    applyStimulus(1'b1, 18'h108, 1'b0, 1'b0);
    tick();
    checkOutput("pre_flush_level", 32'(level), 32'd3);
    applyStimulus(1'b1, 18'h3FFFF, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b0, 1'b0);
    checkOutput("flush_level",     32'(level),     32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready",  32'(in_ready),  32'd1);
    checkOutput("flush_keep_data", 32'(out_data),  32'h106);
`ifdef DSP_FIFO_STALL_CNT_EN
    checkOutput("flush_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // One push after flush: level 1 proves the flushed push was dropped.
    applyStimulus(1'b1, 18'h55, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b0, 1'b0);
    checkOutput("post_flush_level", 32'(level),    32'd1);
    checkOutput("post_flush_head",  32'(out_data), 32'h55);

    // Reset mid-transfer: asynchronous, everything cleared.
    RST = 1'b0;
    #1;
    checkOutput("midrst_level",     32'(level),     32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data",  32'(out_data),  32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd0);
    tick();
    RST = 1'b1;
    #1;
    checkOutput("midrst_rel_in_ready", 32'(in_ready), 32'd1);

`ifdef DSP_FIFO_STALL_CNT_EN
    // Saturation of the stall counter.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 18'(32'h200 + i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("sat_pre_level", 32'(level), 32'd4);
    applyStimulus(1'b1, 18'h3FFFF, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_stream_fifo.md
Name: dsp_stream_fifo

Overview:
- Elastic buffer on the read side of the DSP datapath's registered operand and result streams.
- Accepts SIZE-bit words from a producer (e.g. the PCOUT/M register stage) with a valid/ready handshake.
- Stores up to DEPTH words and presents them first-word-fall-through to a consumer that can apply backpressure.
- Adds flow control to the otherwise free-running enable-gated pipeline registers.

Parameters:
- SIZE, 18, data word width in bits.
- DEPTH, 4, storage entries; power of two, 2..256. Pointer width is log2(DEPTH). Level width is log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of contents. Priority over push and pop.
- in_data  input  SIZE  write data.
- in_valid  input  1  producer has a word.
- in_ready  output  1  FIFO can accept. Push occurs when in_valid && in_ready.
- out_data  output  SIZE  head word.
- out_valid  output  1  head word present.
- out_ready  input  1  consumer takes head. Pop occurs when out_valid && out_ready.
- level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (RST=0, asynchronous):
  - Pointers and level go to 0; out_valid=0; out_data=0.
  - in_ready is forced 0 while RST=0.
  - Storage contents are don't-care.
- Release from reset: in_ready=1 in the first cycle RST=1.
- in_ready = (level != DEPTH). It is a function of registered state only; there is no combinational path from out_ready to in_ready.
- out_valid = (level != 0), registered.
- Write-to-read latency:
  - A word pushed at edge N appears on out_data with out_valid=1 after edge N.
  - The consumer sees it in cycle N+1. No bypass in the same cycle.
- out_data:
  - Always equals the entry at the read pointer.
  - Stable while out_valid && !out_ready.
  - When empty, holds the last popped value (0 after reset).
- Push only: write entry at wr_ptr, wr_ptr+1, level+1.
- Pop only: rd_ptr+1, level-1.
- Push and pop in the same cycle (0<level<DEPTH): both occur, level unchanged, order preserved.
- Full (level=DEPTH):
  - in_ready=0, so a push cannot occur.
  - A pop that cycle reduces level to DEPTH-1; in_ready returns to 1 the next cycle.
- Empty (level=0):
  - out_valid=0, so a pop cannot occur.
  - A push makes level 1.
- Pointers wrap modulo DEPTH with no gap; full vs empty is resolved by level, not by pointer compare.
- flush=1:
  - Pointers and level go to 0 at the next edge; out_valid=0 the next cycle.
  - A push or pop asserted in the same cycle is discarded.
  - out_data keeps its value.
- Reset mid-transfer: all stored words are lost. No partial state survives.
- in_data is sampled only on a push edge. in_data and in_valid are ignored when in_ready=0.

Optional Feature:
- Macro: DSP_FIFO_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0]: a saturating counter of cycles with in_valid=1 && in_ready=0.
  - Holds at 16'hFFFF once saturated.
  - Cleared to 0 by RST or flush.
  - Increments on the same edge the stall cycle is sampled.
- Not defined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset/idle: hold RST=0 for 3 cycles with in_valid=1 and in_data=18'h155 -> in_ready=0, out_valid=0, out_data=0, level=0. After release: in_ready=1, level=0.
- Fill to full (DEPTH=4, out_ready=0): push 1,2,3,4 on consecutive cycles -> level 1,2,3,4; in_ready=0 after the 4th push. A 5th word 18'h3FFFF held on in_data is not stored.
- Drain order: from full, out_ready=1 for 4 cycles -> out_data 1,2,3,4 in order; level 3,2,1,0; out_valid=0 after the 4th pop. out_data stays 4.
- Simultaneous push and pop:
  - At level=2, push 18'h2AAAA and pop in the same cycle -> level stays 2; the popped word is the oldest.
  - Then 8 cycles of continuous push+pop -> the read and write pointers wrap with no loss or duplication; output sequence equals input sequence.
- Flush: at level=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, in_ready=1. Neither the push nor the pop takes effect.
- Stall counter (macro defined):
  - Hold full with in_valid=1 for 5 cycles -> stall_cnt=5.
  - Flush -> stall_cnt=0.
  - Force 70000 stall cycles -> stall_cnt=16'hFFFF.
